acc_bank: RTL and testbench
===========================

# acc_bank

Parametrised successor to the single 8-bit accumulator: a bank of NUM_ACC accumulators of WIDTH bits with an extended source set (zero, ALU, memory, one, increment/decrement by step), optional saturating arithmetic, and an on-block LIFO save/restore stack for loop-nesting context. It sits between the ALU/data-memory paths and the control unit. The control unit drives source, select and stack commands. The block returns the selected value plus zero and stack status flags.

## Interface
- WIDTH, 8, accumulator and data width
- NUM_ACC, 4, number of accumulators (>=1); select width SEL_W = max(1, $clog2(NUM_ACC))
- STACK_DEPTH, 8, save/restore stack entries (>=2)
- SATURATE, 0, 1 = INC/DEC clamp at 0 / 2^WIDTH-1; 0 = modular wrap
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- acc_write  in  1 (CONTROL)  load selected accumulator from acc_src
- acc_src  in  3 (ACC_SRC_X)  load source
- acc_sel  in  SEL_W  selected accumulator (read and write)
- alu_out  in  WIDTH  ALU result
- mem_out  in  WIDTH  memory read data
- step  in  WIDTH  INC/DEC operand
- push  in  1  save selected accumulator to stack
- pop  in  1  restore stack top into selected accumulator
- err_clr  in  1  clear stack_err
- acc_out  out  WIDTH  selected accumulator, combinational read
- acc_zero  out  1  acc_out == 0
- stack_full  out  1  depth == STACK_DEPTH
- stack_empty  out  1  depth == 0
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- Sources: ZERO→0; ALU→alu_out; MEM→mem_out; ONE→1; INC→acc+step; DEC→acc−step; codes 6–7 → hold, no error.
- INC/DEC arithmetic: computed at WIDTH+1 bits. Wrap mode keeps the low WIDTH bits. Saturate mode clamps on carry (INC) or borrow (DEC).
- Only acc[acc_sel] changes. All other entries hold.
- Push: stack[depth] ← acc[acc_sel] (pre-write value); depth+1. A simultaneous acc_write still updates the accumulator.
- Pop: acc[acc_sel] ← stack[depth−1]; depth−1. Pop has priority over acc_write, which is ignored that cycle.
- Push+pop in the same cycle with depth>0 is a swap: the accumulator gets the old top, the top gets the old accumulator, and depth is unchanged. acc_write is ignored.
- Push when full, pop when empty, or push+pop when empty: no state change, stack_err←1. acc_write still applies if no pop is accepted.
- stack_err: sticky. Cleared by err_clr, but a same-cycle new error wins (stays 1).
- Stack stores values only, not accumulator index. Restore targets the current acc_sel.

## Timing
- Reset: all accumulators 0, depth 0, stack_err 0. Hence acc_out=0, acc_zero=1, stack_empty=1, stack_full=0. Stack storage need not be reset.
- Writes, push, pop and flag updates take effect on the rising edge. Updated values are visible on acc_out/flags in the following cycle.
- acc_out/acc_zero follow acc_sel combinationally (zero-latency read).
- Reset asserted mid-sequence clears all state immediately, regardless of clk.
- Back-to-back push/pop every cycle is supported, with no bubbles.

## Structure
- definitions package: ACC_SRC_X enum (ACC_ZERO=0, ACC_ALU=1, ACC_MEM=2, ACC_ONE=3, ACC_INC=4, ACC_DEC=5) alongside existing CONTROL. Add an ACC_SRC_X_W=3 constant.
- Sub-module acc_stack: parametrised LIFO (WIDTH, STACK_DEPTH) with push/pop/swap, full/empty, overflow/underflow strobes. acc_bank owns the sticky err register.
- Source mux and saturating adder are inline in acc_bank.

## Test plan
- Reset then idle: acc_out=0, acc_zero=1, stack_empty=1, stack_err=0 for every acc_sel.
- WIDTH=8, SATURATE=0: load acc0 ONE, INC step=0xFF → 0x00, acc_zero=1. DEC step=1 → 0xFF.
- SATURATE=1: acc2=0xF0, INC step=0x20 → 0xFF. DEC step=0xFF → 0x00. acc1/acc3 unchanged.
- Push acc1=0x11, push acc1=0x22, then write acc1 MEM=0x33. Pop → 0x22, pop → 0x11, stack_empty=1. Third pop → acc unchanged, stack_err=1. Then err_clr → 0.
- Fill STACK_DEPTH pushes → stack_full=1. Extra push → stack_err=1, depth unchanged. Push+pop with top=0xAA, acc=0x55 → acc=0xAA, top=0x55.
- Assert reset asynchronously between clock edges with stack half full: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/acc_bank_pkg.sv
// Shared definitions for the accumulator bank: control encoding, load-source codes
// and the select-width helper.
package acc_bank_pkg;

  typedef enum logic {
    CTRL_OFF = 1'b0,
    CTRL_ON  = 1'b1
  } CONTROL;

  localparam int ACC_SRC_X_W = 3;

  typedef enum logic [ACC_SRC_X_W-1:0] {
    ACC_ZERO = 3'd0,
    ACC_ALU  = 3'd1,
    ACC_MEM  = 3'd2,
    ACC_ONE  = 3'd3,
    ACC_INC  = 3'd4,
    ACC_DEC  = 3'd5
  } ACC_SRC_X;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_stack.sv
// LIFO of accumulator values with push, pop and same-cycle swap; reports
// full/empty and single-cycle overflow/underflow strobes for rejected commands.
module acc_stack
  import acc_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]    depth;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  assign full      = (depth == DW'(STACK_DEPTH));
  assign empty     = (depth == '0);
  assign wr_idx    = depth[IW-1:0];
  assign top_idx   = empty ? '0 : IW'(depth - DW'(1));
  assign top       = mem[top_idx];
  assign overflow  = push && !pop && full;
  // push+pop on an empty stack is rejected as an underflow, not a swap
  assign underflow = pop && empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
    end else if (push && !pop && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !push && !empty) begin
      depth <= depth - DW'(1);
    end
  end

  // storage carries no reset; only depth defines which entries are valid
  always_ff @(posedge clk) begin
    if (push && pop && !empty) begin
      mem[top_idx] <= din;
    end else if (push && !pop && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with selectable load source, wrap/saturating
// increment/decrement and a save/restore stack for nested-loop context.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_ACC     = 4,
  parameter int STACK_DEPTH = 8,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        acc_write,
  input  logic [ACC_SRC_X_W-1:0]      acc_src,
  input  logic [sel_w(NUM_ACC)-1:0]   acc_sel,
  input  logic [WIDTH-1:0]            alu_out,
  input  logic [WIDTH-1:0]            mem_out,
  input  logic [WIDTH-1:0]            step,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        err_clr,
  output logic [WIDTH-1:0]            acc_out,
  output logic                        acc_zero,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        stack_err
);

  logic [WIDTH-1:0] acc [NUM_ACC];
  logic             in_range;
  logic [WIDTH-1:0] stack_top;
  logic             overflow;
  logic             underflow;
  logic             pop_ok;
  logic             src_valid;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  ACC_SRC_X         src;

  assign in_range = (32'(acc_sel) < NUM_ACC);
  assign acc_out  = in_range ? acc[acc_sel] : '0;
  assign acc_zero = (acc_out == '0);
  assign src      = ACC_SRC_X'(acc_src);
  assign sum      = {1'b0, acc_out} + {1'b0, step};
  assign diff     = {1'b0, acc_out} - {1'b0, step};
  assign pop_ok   = pop && !stack_empty;

  always_comb begin
    src_valid = 1'b1;
    src_val   = acc_out;
    case (src)
      ACC_ZERO: src_val = '0;
      ACC_ALU:  src_val = alu_out;
      ACC_MEM:  src_val = mem_out;
      ACC_ONE:  src_val = WIDTH'(1);
      ACC_INC:  src_val = (SATURATE && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
      ACC_DEC:  src_val = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default:  src_valid = 1'b0;
    endcase
  end

  // an accepted pop (including a swap) overrides acc_write
  assign next_val = pop_ok ? stack_top : src_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (in_range && (pop_ok || (acc_write && src_valid))) begin
      acc[acc_sel] <= next_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else if (overflow || underflow) begin
      stack_err <= 1'b1;
    end else if (err_clr) begin
      stack_err <= 1'b0;
    end
  end

  acc_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (acc_out),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule

// File: tb/tb_acc_bank.sv
// Directed checks for acc_bank: a wrap-mode and a saturating instance driven with
// identical stimulus, vector table plus hand sequences for stack and reset corners.
module tb_acc_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       acc_write = 1'b0;
  logic [2:0] acc_src = '0;
  logic [1:0] acc_sel = '0;
  logic [7:0] alu_out = '0;
  logic [7:0] mem_out = '0;
  logic [7:0] step = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] w_out, s_out;
  logic       w_zero, s_zero, w_full, s_full, w_empty, s_empty, w_err, s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(8), .NUM_ACC(4), .STACK_DEPTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .acc_write(acc_write), .acc_src(acc_src),
    .acc_sel(acc_sel), .alu_out(alu_out), .mem_out(mem_out), .step(step),
    .push(push), .pop(pop), .err_clr(err_clr), .acc_out(w_out),
    .acc_zero(w_zero), .stack_full(w_full), .stack_empty(w_empty), .stack_err(w_err)
  );

  acc_bank #(.WIDTH(8), .NUM_ACC(4), .STACK_DEPTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .acc_write(acc_write), .acc_src(acc_src),
    .acc_sel(acc_sel), .alu_out(alu_out), .mem_out(mem_out), .step(step),
    .push(push), .pop(pop), .err_clr(err_clr), .acc_out(s_out),
    .acc_zero(s_zero), .stack_full(s_full), .stack_empty(s_empty), .stack_err(s_err)
  );

  typedef struct {
    logic       wr;
    logic [2:0] src;
    logic [1:0] sel;
    logic [7:0] alu;
    logic [7:0] mem;
    logic [7:0] stp;
    logic       psh;
    logic       pp;
    logic       clr;
    logic [7:0] e_out;
    logic       e_zero;
    logic       e_empty;
    logic       e_full;
    logic       e_err;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of commands, then drop the strobes just after the edge
  task automatic op(input logic wr, input logic [2:0] src, input logic [1:0] sel,
                    input logic [7:0] alu, input logic [7:0] mem, input logic [7:0] stp,
                    input logic psh, input logic pp, input logic clr);
    acc_write = wr; acc_src = src; acc_sel = sel; alu_out = alu; mem_out = mem;
    step = stp; push = psh; pop = pp; err_clr = clr;
    @(posedge clk);
    #1;
    acc_write = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr_alu(input logic [1:0] sel, input logic [7:0] v);
    op(1'b1, 3'd1, sel, v, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd4, 2'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd5, 2'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 2'd1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 2'd1, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 2'd1, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'd1, 2'd1, 8'h77, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 3'd6, 2'd1, 8'h99, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 3'd1, 2'd2, 8'h44, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // reset state on every select, both instances
    for (int s = 0; s < 4; s++) begin
      acc_sel = 2'(s);
      #1;
      check($sformatf("rst_out_w%0d", s), 32'(w_out), 32'h0);
      check($sformatf("rst_out_s%0d", s), 32'(s_out), 32'h0);
      check($sformatf("rst_zero%0d", s), {w_zero, s_zero}, 2'b11);
      check($sformatf("rst_flags%0d", s), {w_empty, w_full, w_err}, 3'b100);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      op(vecs[i].wr, vecs[i].src, vecs[i].sel, vecs[i].alu, vecs[i].mem, vecs[i].stp,
         vecs[i].psh, vecs[i].pp, vecs[i].clr);
      check($sformatf("v%0d_out", i), 32'(w_out), 32'(vecs[i].e_out));
      check($sformatf("v%0d_zero", i), 32'(w_zero), 32'(vecs[i].e_zero));
      check($sformatf("v%0d_empty", i), 32'(w_empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_full", i), 32'(w_full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_err", i), 32'(w_err), 32'(vecs[i].e_err));
    end

    // saturating vs wrapping INC/DEC on acc2
    wr_alu(2'd2, 8'hF0);
    op(1'b1, 3'd4, 2'd2, 8'h00, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
    check("sat_inc", 32'(s_out), 32'hFF);
    check("wrap_inc", 32'(w_out), 32'h10);
    op(1'b1, 3'd5, 2'd2, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("sat_dec", 32'(s_out), 32'h00);
    check("sat_dec_zero", 32'(s_zero), 32'h1);
    check("wrap_dec", 32'(w_out), 32'h11);
    op(1'b1, 3'd5, 2'd2, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    check("sat_dec_clamp", 32'(s_out), 32'h00);
    check("wrap_dec2", 32'(w_out), 32'h10);
    acc_sel = 2'd1;
    #1;
    check("sat_acc1_hold", 32'(s_out), 32'h11);
    acc_sel = 2'd3;
    #1;
    check("sat_acc3_hold", 32'(s_out), 32'h00);

    // fill the stack from acc3
    for (int i = 0; i < 8; i++) begin
      wr_alu(2'd3, 8'hA0 + 8'(i));
      op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      check($sformatf("fill%0d_full", i), 32'(w_full), (i == 7) ? 32'h1 : 32'h0);
      check($sformatf("fill%0d_empty", i), 32'(w_empty), 32'h0);
    end
    op(1'b1, 3'd1, 2'd3, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("ovf_err", 32'(w_err), 32'h1);
    check("ovf_full", 32'(w_full), 32'h1);
    check("ovf_write_applies", 32'(w_out), 32'h5A);
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(w_err), 32'h0);
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pop_top", 32'(w_out), 32'hA7);
    check("pop_notfull", 32'(w_full), 32'h0);

    // swap with top=AA, acc=55; concurrent write is ignored
    wr_alu(2'd3, 8'hAA);
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    wr_alu(2'd3, 8'h55);
    op(1'b1, 3'd1, 2'd3, 8'h66, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    check("swap_acc", 32'(w_out), 32'hAA);
    check("swap_depth", 32'(w_full), 32'h1);
    check("swap_noerr", 32'(w_err), 32'h0);
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("swap_top", 32'(w_out), 32'h55);
    check("swap_pop_notfull", 32'(w_full), 32'h0);

    // refill, overflow, then pop down to half full with the error still sticky
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("ovf2_err", 32'(w_err), 32'h1);
    for (int i = 0; i < 4; i++) op(1'b0, 3'd0, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("half_err_sticky", 32'(w_err), 32'h1);
    check("half_flags", {w_empty, w_full}, 2'b00);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_w", 32'(w_out), 32'h0);
    check("areset_out_s", 32'(s_out), 32'h0);
    check("areset_zero", {w_zero, s_zero}, 2'b11);
    check("areset_flags_w", {w_empty, w_full, w_err}, 3'b100);
    check("areset_flags_s", {s_empty, s_full, s_err}, 3'b100);
    acc_sel = 2'd1;
    #1;
    check("areset_acc1", 32'(w_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    wr_alu(2'd0, 8'h3C);
    check("post_reset_write", 32'(w_out), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
